// File: rtl/bsg_arb_rr_one_hot_hold_pkg.sv
// Shared types and width helpers for the round-robin one-hot hold arbiter.
package bsg_arb_rr_one_hot_hold_pkg;

    typedef enum logic [0:0] {
        e_arb_idle  = 1'b0,
        e_arb_grant = 1'b1
    } arb_state_e;

    // Index width with a floor of one bit so degenerate sizes still elaborate.
    function automatic int lg(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int els_default_lp        = 16;
    localparam int max_beats_default_lp  = 4;
    localparam int tag_width_default_lp  = lg(els_default_lp);
    localparam int beat_width_default_lp = lg(max_beats_default_lp);

endpackage

// File: rtl/bsg_arb_rr_one_hot_hold_if.sv
// Requester/consumer bundle of the arbiter, plus debug taps for state and beat count.
interface bsg_arb_rr_one_hot_hold_if
    import bsg_arb_rr_one_hot_hold_pkg::*;
#(
    parameter int els_p       = els_default_lp,
    parameter int max_beats_p = max_beats_default_lp
);
    localparam int tag_w_lp   = lg(els_p);
    localparam int beats_w_lp = lg(max_beats_p);

    // Handshake: a transfer happens on a posedge where v_o=1 and yumi_i=1; grants_o/tag_o
    // stay constant while v_o=1 and yumi_i=0, and yumi_i must be 0 whenever v_o=0.
    logic                  en_i;
    logic [els_p-1:0]      reqs_i;
    logic                  lock_i;
    logic                  yumi_i;
    logic                  v_o;
    logic [els_p-1:0]      grants_o;
    logic [tag_w_lp-1:0]   tag_o;
    logic [els_p-1:0]      ptr_r_o;
    arb_state_e            state_o;
    logic [beats_w_lp-1:0] beats_o;

    modport master (
        output en_i, reqs_i, lock_i, yumi_i,
        input  v_o, grants_o, tag_o, ptr_r_o, state_o, beats_o
    );

    modport slave (
        input  en_i, reqs_i, lock_i, yumi_i,
        output v_o, grants_o, tag_o, ptr_r_o, state_o, beats_o
    );

endinterface

// File: rtl/bsg_arb_rr_one_hot_hold_one_hot_rotate_ptr.sv
// One-hot priority pointer: resets to bit 0, loads a new one-hot value or rotates left by one.
module bsg_one_hot_rotate_ptr #(
    parameter int els_p = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             advance_i,
    input  logic             load_i,
    input  logic [els_p-1:0] data_i,
    output logic [els_p-1:0] ptr_o
);
    logic [els_p-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = data_i;
        end else if (advance_i) begin
            ptr_d = {ptr_q[els_p-2:0], ptr_q[els_p-1]};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q <= els_p'(1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/bsg_arb_rr_one_hot_hold.sv
// Round-robin arbiter with a registered grant held until yumi, optional lock for bounded bursts.
module bsg_arb_rr_one_hot_hold
    import bsg_arb_rr_one_hot_hold_pkg::*;
#(
    parameter int els_p       = els_default_lp,
    parameter int max_beats_p = max_beats_default_lp
) (
    input logic                       clk_i,
    input logic                       reset_i,
    bsg_arb_rr_one_hot_hold_if.slave  bus
);
    localparam int tag_w_lp   = lg(els_p);
    localparam int beats_w_lp = lg(max_beats_p);
    localparam logic [beats_w_lp-1:0] beats_last_lp = beats_w_lp'(max_beats_p - 1);

    arb_state_e            state_q, state_d;
    logic [els_p-1:0]      grant_q, grant_d;
    logic [beats_w_lp-1:0] beats_q, beats_d;

    logic [els_p-1:0]      ptr_r;
    logic [els_p-1:0]      rot_grant;
    logic [els_p-1:0]      scan_ptr;
    logic [els_p-1:0]      upper_reqs;
    logic [els_p-1:0]      winner;
    logic [tag_w_lp-1:0]   tag;
    logic                  ptr_load;
    logic                  any_req;
    logic                  keep_lock;

    assign rot_grant = {grant_q[els_p-2:0], grant_q[els_p-1]};
    assign any_req   = |bus.reqs_i;

    // While granted, the only arbitration that matters is the zero-bubble one on release,
    // which must already see the pointer just past the current grantee.
    assign scan_ptr  = (state_q == e_arb_grant) ? rot_grant : ptr_r;

    // Requests at or above the pointer win first; otherwise wrap to the lowest request.
    assign upper_reqs = bus.reqs_i & ~(scan_ptr - els_p'(1));
    always_comb begin
        if (|upper_reqs) begin
            winner = upper_reqs & (~upper_reqs + els_p'(1));
        end else begin
            winner = bus.reqs_i & (~bus.reqs_i + els_p'(1));
        end
    end

    always_comb begin
        tag = '0;
        for (int i = 0; i < els_p; i++) begin
            if (grant_q[i]) begin
                tag = tag | tag_w_lp'(i);
            end
        end
    end

    assign keep_lock = bus.lock_i && (|(bus.reqs_i & grant_q)) && (beats_q < beats_last_lp);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        beats_d  = beats_q;
        ptr_load = 1'b0;
        case (state_q)
            e_arb_idle: begin
                if (bus.en_i && any_req) begin
                    state_d = e_arb_grant;
                    grant_d = winner;
                end
            end
            e_arb_grant: begin
                if (bus.yumi_i) begin
                    if (keep_lock) begin
                        beats_d = beats_q + beats_w_lp'(1);
                    end else begin
                        ptr_load = 1'b1;
                        beats_d  = '0;
                        if (bus.en_i && any_req) begin
                            grant_d = winner;
                        end else begin
                            state_d = e_arb_idle;
                            grant_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = e_arb_idle;
                grant_d = '0;
                beats_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= e_arb_idle;
            grant_q <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beats_q <= beats_d;
        end
    end

    bsg_one_hot_rotate_ptr #(.els_p(els_p)) ptr_reg (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .advance_i(1'b0),
        .load_i   (ptr_load),
        .data_i   (rot_grant),
        .ptr_o    (ptr_r)
    );

    assign bus.v_o      = (state_q == e_arb_grant);
    assign bus.grants_o = grant_q;
    assign bus.tag_o    = tag;
    assign bus.ptr_r_o  = ptr_r;
    assign bus.state_o  = state_q;
    assign bus.beats_o  = beats_q;

    a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i)
        bus.yumi_i |-> bus.v_o)
        else $error("yumi_i asserted with no grant presented");

    a_grantee_holds_req: assert property (@(posedge clk_i) disable iff (reset_i)
        bus.v_o |-> |(bus.reqs_i & grant_q))
        else $error("granted requester dropped its request");

    a_grant_onehot0: assert property (@(posedge clk_i) disable iff (reset_i)
        $onehot0(grant_q))
        else $error("grant vector not one-hot");

    a_ptr_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
        $onehot(ptr_r))
        else $error("priority pointer not one-hot");

endmodule
